// File: rtl/rr_select_arb.sv
// Round-robin arbiter producing registered one-hot and binary mux selects.
// The select is held until the downstream valid/ready handshake completes.
module rr_select_arb #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            ready,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gntidx,
    output logic            valid,
    output logic            busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [IDXW:0]   LP_N    = (IDXW + 1)'(N);
    localparam logic [IDXW-1:0] LP_LAST = IDXW'(N - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] w_ptr_next;
    logic [IDXW-1:0] r_gntidx;
    logic [IDXW-1:0] w_gntidx_next;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    w_gnt_next;
    logic            r_valid;
    logic            w_valid_next;

    logic [IDXW-1:0] w_ptr_adv;
    logic [IDXW-1:0] w_base;
    logic [IDXW-1:0] w_cand [N];
    logic [N-1:0]    w_hit;
    logic            w_any;
    logic [IDXW-1:0] w_win;
    logic [N-1:0]    w_win_onehot;

    // Pointer after serving the current grantee; wraps at N, not 2^IDXW.
    assign w_ptr_adv = (r_gntidx == LP_LAST) ? '0 : r_gntidx + IDXW'(1);

    // Re-arbitration on a completed handshake already uses the advanced pointer.
    assign w_base = (r_state == S_GRANT && ready) ? w_ptr_adv : r_ptr;

    // Candidate gi is the requester at scan position gi from the base pointer.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            localparam logic [IDXW:0] LP_GI = (IDXW + 1)'(gi);
            logic [IDXW:0] w_sum;
            assign w_sum       = {1'b0, w_base} + LP_GI;
            assign w_cand[gi]  = IDXW'((w_sum >= LP_N) ? (w_sum - LP_N) : w_sum);
            assign w_hit[gi]   = req[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_any = 1'b1;
                w_win = w_cand[k];
            end
        end
    end

    always_comb begin
        w_win_onehot        = '0;
        w_win_onehot[w_win] = 1'b1;
    end

    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_ptr;
        w_gnt_next    = r_gnt;
        w_gntidx_next = r_gntidx;
        w_valid_next  = r_valid;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next  = S_GRANT;
                    w_gnt_next    = w_win_onehot;
                    w_gntidx_next = w_win;
                    w_valid_next  = 1'b1;
                end
            end
            S_GRANT: begin
                if (ready) begin
                    w_ptr_next = w_ptr_adv;
                    if (w_any) begin
                        w_gnt_next    = w_win_onehot;
                        w_gntidx_next = w_win;
                    end else begin
                        w_state_next  = S_IDLE;
                        w_gnt_next    = '0;
                        w_gntidx_next = '0;
                        w_valid_next  = 1'b0;
                    end
                end else if (!req[r_gntidx]) begin
                    // Requester withdrew before acceptance: drop without advancing.
                    w_state_next  = S_IDLE;
                    w_gnt_next    = '0;
                    w_gntidx_next = '0;
                    w_valid_next  = 1'b0;
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_gnt_next    = '0;
                w_gntidx_next = '0;
                w_valid_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_gntidx <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ptr    <= w_ptr_next;
            r_gnt    <= w_gnt_next;
            r_gntidx <= w_gntidx_next;
            r_valid  <= w_valid_next;
        end
    end

    assign gnt    = r_gnt;
    assign gntidx = r_gntidx;
    assign valid  = r_valid;
    assign busy   = (r_state == S_GRANT);

endmodule

// File: tb/tb_rr_select_arb.sv
// Directed bench for rr_select_arb: N=4 instance for the main plan and an
// N=5 instance for the non-power-of-2 wrap.
module tb_rr_select_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       ready;
    logic [3:0] gnt;
    logic [1:0] gntidx;
    logic       valid;
    logic       busy;

    logic       reset5;
    logic [4:0] req5;
    logic       ready5;
    logic [4:0] gnt5;
    logic [2:0] gntidx5;
    logic       valid5;
    logic       busy5;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    rr_select_arb #(.N(4), .IDXW(2)) dut (
        .clk(clk), .reset(reset), .req(req), .ready(ready),
        .gnt(gnt), .gntidx(gntidx), .valid(valid), .busy(busy)
    );

    rr_select_arb #(.N(5), .IDXW(3)) dut5 (
        .clk(clk), .reset(reset5), .req(req5), .ready(ready5),
        .gnt(gnt5), .gntidx(gntidx5), .valid(valid5), .busy(busy5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then structural invariants on both instances.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t req=%b ready=%b gnt=%b idx=%0d valid=%b | req5=%b gnt5=%b idx5=%0d valid5=%b",
                 $time, req, ready, gnt, gntidx, valid, req5, gnt5, gntidx5, valid5);
        chk("inv_gnt_vs_idx", {28'b0, gnt}, valid ? (32'd1 << gntidx) : 32'd0);
        chk("inv_busy", {31'b0, busy}, {31'b0, valid});
        chk("inv5_gnt_vs_idx", {27'b0, gnt5}, valid5 ? (32'd1 << gntidx5) : 32'd0);
        chk("inv5_idx_lt_n", {31'b0, (gntidx5 < 3'd5)}, 32'd1);
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic v);
        chk({tag, "_gnt"}, {28'b0, gnt}, {28'b0, g});
        chk({tag, "_idx"}, {30'b0, gntidx}, {30'b0, idx});
        chk({tag, "_valid"}, {31'b0, valid}, {31'b0, v});
    endtask

    initial begin
        reset  = 1'b1; req  = 4'b0000; ready  = 1'b0;
        reset5 = 1'b1; req5 = 5'b00000; ready5 = 1'b0;
        tick();
        tick();
        expect_grant("reset", 4'b0000, 2'd0, 1'b0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_ptr", {30'b0, dut.r_ptr}, 32'd0);

        // Full-load rotation from the reset pointer.
        reset = 1'b0; req = 4'b1111; ready = 1'b1;
        tick(); expect_grant("rot0", 4'b0001, 2'd0, 1'b1);
        tick(); expect_grant("rot1", 4'b0010, 2'd1, 1'b1);
        tick(); expect_grant("rot2", 4'b0100, 2'd2, 1'b1);
        tick(); expect_grant("rot3", 4'b1000, 2'd3, 1'b1);
        tick(); expect_grant("rot4", 4'b0001, 2'd0, 1'b1);

        // Asynchronous reset in the middle of a grant.
        #2 reset = 1'b1;
        #1;
        expect_grant("async_rst", 4'b0000, 2'd0, 1'b0);
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        tick(); expect_grant("post_rst", 4'b0001, 2'd0, 1'b1);

        // Single requester: drain first, then request idx1 and drop it.
        req = 4'b0000;
        tick(); expect_grant("drain", 4'b0000, 2'd0, 1'b0);
        req = 4'b0010;
        tick(); expect_grant("single", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        tick(); expect_grant("single_done", 4'b0000, 2'd0, 1'b0);
        chk("single_ptr", {30'b0, dut.r_ptr}, 32'd2);

        // Hold under backpressure, then abort when the grantee withdraws.
        reset = 1'b1;
        tick();
        reset = 1'b0; req = 4'b0101; ready = 1'b0;
        tick(); expect_grant("hold_start", 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            req = (i % 2 == 0) ? 4'b0111 : 4'b0101;
            tick(); expect_grant($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b1);
        end
        req = 4'b0100;
        tick(); expect_grant("abort", 4'b0000, 2'd0, 1'b0);
        chk("abort_ptr", {30'b0, dut.r_ptr}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        tick(); expect_grant("after_abort", 4'b0100, 2'd2, 1'b1);

        // Served requester becomes lowest priority after a held grant.
        reset = 1'b1;
        tick();
        reset = 1'b0; req = 4'b1111; ready = 1'b0;
        tick(); expect_grant("bp_first", 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_grant($sformatf("bp_hold%0d", i), 4'b0001, 2'd0, 1'b1);
        end
        ready = 1'b1;
        tick(); expect_grant("bp_next", 4'b0010, 2'd1, 1'b1);

        // ready together with withdrawal of the grantee counts as accepted.
        req = 4'b1101;
        tick(); expect_grant("rdy_withdraw", 4'b0100, 2'd2, 1'b1);
        chk("rdy_withdraw_ptr", {30'b0, dut.r_ptr}, 32'd2);

        // Non-power-of-2 wrap on the N=5 instance.
        req = 4'b0000; ready = 1'b0;
        reset5 = 1'b0; req5 = 5'b10001; ready5 = 1'b1;
        tick(); chk("n5_g0_idx", {29'b0, gntidx5}, 32'd0); chk("n5_g0_gnt", {27'b0, gnt5}, 32'h01);
        tick(); chk("n5_g1_idx", {29'b0, gntidx5}, 32'd4); chk("n5_g1_gnt", {27'b0, gnt5}, 32'h10);
        tick(); chk("n5_g2_idx", {29'b0, gntidx5}, 32'd0); chk("n5_g2_ptr", {29'b0, dut5.r_ptr}, 32'd0);
        tick(); chk("n5_g3_idx", {29'b0, gntidx5}, 32'd4); chk("n5_g3_valid", {31'b0, valid5}, 32'd1);
        req5 = 5'b00000;
        tick(); chk("n5_idle_valid", {31'b0, valid5}, 32'd0);
        chk("n5_idle_ptr", {29'b0, dut5.r_ptr}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
